// File: rtl/byte_enable_regfile.sv
// 32 x 32-bit MIPS register file with per-byte write enables, two bypassed
// combinational read ports and one unbypassed debug read port.
module byte_enable_regfile #(
  parameter int unsigned NREG = 32,
  parameter int unsigned DW   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        raddr1,
  output logic [DW-1:0]     rdata1,
  input  logic [4:0]        raddr2,
  output logic [DW-1:0]     rdata2,
  input  logic              we,
  input  logic [4:0]        waddr,
  input  logic [DW/8-1:0]   wbe,
  input  logic [DW-1:0]     wdata,
  input  logic [4:0]        dbg_addr,
  output logic [DW-1:0]     dbg_data
);

  localparam int unsigned NB = DW / 8;

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] bmask;
  logic          wr_en;

  assign wr_en = we && (waddr != 5'd0);

  always_comb begin
    bmask = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      bmask[8*i +: 8] = {8{wbe[i]}};
    end
  end

  // Flop storage: per-byte enables plus synchronous clear of every entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[waddr] <= (regs_q[waddr] & ~bmask) | (wdata & bmask);
    end
  end

  // Bypass returns the value the register will hold after this edge.
  always_comb begin
    rdata1 = '0;
    if (!reset && raddr1 != 5'd0) begin
      if (wr_en && waddr == raddr1) begin
        rdata1 = (regs_q[raddr1] & ~bmask) | (wdata & bmask);
      end else begin
        rdata1 = regs_q[raddr1];
      end
    end
  end

  always_comb begin
    rdata2 = '0;
    if (!reset && raddr2 != 5'd0) begin
      if (wr_en && waddr == raddr2) begin
        rdata2 = (regs_q[raddr2] & ~bmask) | (wdata & bmask);
      end else begin
        rdata2 = regs_q[raddr2];
      end
    end
  end

  always_comb begin
    dbg_data = '0;
    if (!reset && dbg_addr != 5'd0) begin
      dbg_data = regs_q[dbg_addr];
    end
  end

endmodule
